// File: rtl/mini_core_fab_ingress_pkg.sv
// Shared tile fabric types and ingress constants for the mini_core tile.
package mini_core_pkg;

  typedef logic [7:0] t_tile_id;

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] data;
    logic [3:0]  byteEn;
    logic        write;
  } t_tile_trans;

  localparam int unsigned MINI_FAB_IN_DEPTH = 4;
  localparam int unsigned TILE_ID_MSB       = 31;
  localparam int unsigned TILE_ID_LSB       = 24;

  // Destination tile encoded in the top address byte.
  function automatic t_tile_id tileOf(input t_tile_trans t);
    return t.address[TILE_ID_MSB:TILE_ID_LSB];
  endfunction

endpackage

// File: rtl/mini_core_fab_ingress_if.sv
// Router-side and core-side valid/ready handshake of the fabric ingress buffer.
interface mini_core_fab_ingress_if;
  import mini_core_pkg::*;

  logic        InValidQ502H;
  t_tile_trans InTransQ502H;
  logic        InReadyQ502H;
  logic        OutValidQ503H;
  t_tile_trans OutTransQ503H;
  logic        CoreReady;

  modport slave (
    input  InValidQ502H, InTransQ502H, CoreReady,
    output InReadyQ502H, OutValidQ503H, OutTransQ503H
  );

  modport master (
    output InValidQ502H, InTransQ502H, CoreReady,
    input  InReadyQ502H, OutValidQ503H, OutTransQ503H
  );
endinterface

// File: rtl/mini_core_fab_ingress_fifo.sv
// Generic first-word-fall-through FIFO; DEPTH need not be a power of two.
module mini_core_fab_ingress_fifo #(
  parameter  int unsigned DEPTH = 4,
  parameter  type         T     = logic,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             Clock,
  input  logic             RstN,
  input  logic             Push,
  input  T                 PushData,
  input  logic             Pop,
  output T                 HeadData,
  output logic [CNT_W-1:0] Count,
  output logic [CNT_W-1:0] CountNext,
  output logic             Empty
);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic             popEn;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    Empty     = (Count == '0);
    popEn     = Pop && !Empty;
    CountNext = Count + CNT_W'(Push) - CNT_W'(popEn);
    HeadData  = mem[rdPtr];
  end

  always_ff @(posedge Clock or negedge RstN) begin
    if (!RstN) begin
      rdPtr <= '0;
      wrPtr <= '0;
      Count <= '0;
    end else begin
      if (Push)  wrPtr <= bump(wrPtr);
      if (popEn) rdPtr <= bump(rdPtr);
      Count <= CountNext;
    end
  end

  always_ff @(posedge Clock) begin
    if (Push) mem[wrPtr] <= PushData;
  end

endmodule

// File: rtl/mini_core_fab_ingress.sv
// Fabric ingress buffer: tile-id filter, registered ready, FWFT output.
// Optional same-cycle bypass into an idle core: MINI_CORE_FAB_INGRESS_BYPASS_EN.
module mini_core_fab_ingress
  import mini_core_pkg::*;
#(
  parameter  int unsigned DEPTH = MINI_FAB_IN_DEPTH,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                    Clock,
  input  logic                    RstN,
  input  t_tile_id                local_tile_id,
  mini_core_fab_ingress_if.slave  fab,
  output logic                    MisrouteQ503H,
  output logic [CNT_W-1:0]        OccupancyQ503H
);

  logic             accept;
  logic             inTile;
  logic             push;
  logic             pop;
  logic             empty;
  t_tile_trans      head;
  logic [CNT_W-1:0] countNext;
`ifdef MINI_CORE_FAB_INGRESS_BYPASS_EN
  logic             bypass;
`endif

  mini_core_fab_ingress_fifo #(
    .DEPTH (DEPTH),
    .T     (t_tile_trans)
  ) u_fifo (
    .Clock     (Clock),
    .RstN      (RstN),
    .Push      (push),
    .PushData  (fab.InTransQ502H),
    .Pop       (pop),
    .HeadData  (head),
    .Count     (OccupancyQ503H),
    .CountNext (countNext),
    .Empty     (empty)
  );

  always_comb begin
    accept = fab.InValidQ502H && fab.InReadyQ502H;
    inTile = (tileOf(fab.InTransQ502H) == local_tile_id);
    pop    = !empty && fab.CoreReady;
`ifdef MINI_CORE_FAB_INGRESS_BYPASS_EN
    // An accepted transaction taken straight by an idle, ready core never enters storage.
    bypass            = accept && inTile && empty && fab.CoreReady;
    push              = accept && inTile && !bypass;
    fab.OutValidQ503H = !empty || bypass;
    fab.OutTransQ503H = bypass ? fab.InTransQ502H : head;
`else
    push              = accept && inTile;
    fab.OutValidQ503H = !empty;
    fab.OutTransQ503H = head;
`endif
  end

  always_ff @(posedge Clock or negedge RstN) begin
    if (!RstN) begin
      fab.InReadyQ502H <= 1'b0;
      MisrouteQ503H    <= 1'b0;
    end else begin
      fab.InReadyQ502H <= (countNext < CNT_W'(DEPTH));
      MisrouteQ503H    <= accept && !inTile;
    end
  end

endmodule

// File: doc/mini_core_fab_ingress.md
Name: mini_core_fab_ingress

Overview:
- Ingress buffer between the tile's fabric router output port and the mini_core tile fabric input (InFabricValidQ503H / InFabricQ503H / mini_core_ready).
- Absorbs router bursts while the core memory wrapper is stalled, using a valid/ready FIFO of t_tile_trans.
- Checks that every transaction targets local_tile_id. Misrouted transactions are consumed, dropped, and flagged.

Parameters:
- DEPTH, 4, number of t_tile_trans entries; legal range 2..16, need not be a power of 2.

Ports:
- Clock  in  1  core clock
- RstN  in  1  asynchronous active-low reset
- local_tile_id  in  t_tile_id  this tile's id; static after reset
- InValidQ502H  in  1  router has a transaction
- InTransQ502H  in  t_tile_trans  transaction from router
- InReadyQ502H  out  1  buffer can accept this cycle
- OutValidQ503H  out  1  to InFabricValidQ503H
- OutTransQ503H  out  t_tile_trans  to InFabricQ503H
- CoreReady  in  1  from mini_core_ready
- MisrouteQ503H  out  1  one-cycle pulse: a misrouted transaction was dropped
- OccupancyQ503H  out  $clog2(DEPTH+1)  current entry count

Behaviour:
- Interface rule: one clock (Clock); reset is asynchronous and active-low (RstN).
- Reset values: RstN low clears rd_ptr, wr_ptr and count to 0. Outputs are InReadyQ502H=0, OutValidQ503H=0, MisrouteQ503H=0, OccupancyQ503H=0. OutTransQ503H is don't-care.
- InReadyQ502H is a register. It rises the first Clock edge after RstN deasserts. Each cycle it loads (count_next < DEPTH).
- Accept: InValidQ502H && InReadyQ502H.
  - target = InTransQ502H.address[31:24] compared against local_tile_id.
  - If they match: write mem[wr_ptr] and advance wr_ptr.
  - If they differ: do not store; register MisrouteQ503H=1 for exactly one cycle.
- Output is first-word-fall-through:
  - OutValidQ503H = (count != 0).
  - OutTransQ503H = mem[rd_ptr].
  - Pop occurs on OutValidQ503H && CoreReady.
- Latency: an accepted in-tile transaction into an empty buffer appears on OutValidQ503H the next cycle. There is no same-cycle bypass unless the optional feature is enabled.
- Pointers increment modulo DEPTH: DEPTH-1 wraps to 0.
- count_next = count + push - pop.
  - Simultaneous push and pop leaves count unchanged; both pointers advance.
  - Full (count==DEPTH): InReadyQ502H is already 0, so no push. A pop that cycle raises InReadyQ502H the next cycle.
  - Empty: OutValidQ503H=0; CoreReady is ignored.
- OutTransQ503H holds stable while OutValidQ503H && !CoreReady.
- Reset asserted mid-operation: all contents are discarded immediately (async). No partial transaction is emitted after release.
- Misrouted accepts never change count.

Optional Feature:
- MINI_CORE_FAB_INGRESS_BYPASS_EN defined:
  - When count==0 and CoreReady=1, an accepted in-tile transaction drives OutValidQ503H/OutTransQ503H combinationally in the same cycle and is not written.
  - If CoreReady=0, it is written as normal.
- Not defined: pure registered FIFO with 1-cycle minimum latency. OutValidQ503H has no combinational path from InValidQ502H.

Decomposition:
- mini_core_pkg holds:
  - t_tile_trans and t_tile_id (existing).
  - New constants MINI_FAB_IN_DEPTH=4, TILE_ID_MSB=31, TILE_ID_LSB=24.
- Sub-module mini_core_fab_ingress_fifo:
  - Generic storage, pointers, count, full/empty.
  - Parameterised on DEPTH and a data type.
- The top-level module adds the tile-id check, the registered ready, and the bypass.

Test Plan:
- Reset then idle: RstN low 3 cycles -> all outputs 0. One cycle after release, InReadyQ502H=1 and OutValidQ503H=0.
- Single in-tile transaction, CoreReady=1, local_tile_id=8'h11, address=32'h1100_0040 -> OutValidQ503H=1 next cycle with identical trans. Pops the same cycle; Occupancy returns to 0.
- Fill, DEPTH=4, CoreReady=0: push 4 transactions with data 1..4 -> Occupancy=4 and InReadyQ502H=0. Then raise CoreReady -> outputs data 1,2,3,4 in order on 4 consecutive cycles. InReadyQ502H=1 one cycle after the first pop.
- Wrap with simultaneous push/pop: 10 back-to-back transactions, CoreReady=1 -> all 10 delivered in order, Occupancy ≤1, pointers wrap twice.
- Misroute: address=32'h2200_0000 with local_tile_id=8'h11 -> MisrouteQ503H pulses 1 cycle; OutValidQ503H stays 0; Occupancy stays 0.
- Reset mid-stream: 3 entries held, RstN pulsed low -> OutValidQ503H=0 immediately; no stale trans after release.
